spi_bus_arbiter: RTL and testbench

Shares a single SPI mode-0 master port between two byte-stream requesters. Each requester sends a packet, a run of bytes ending in `last`, and the block serialises it MSB-first under one `spi_cs_n` assertion. Every received byte is returned to the owning requester. The arbiter sits between on-chip traffic sources (test sequencer, config loader) and the external SPI pins; the SPI file-driven tester is the slave-side stimulus used against it.

---
 rtl/spi_bus_arbiter_if.sv | 28 ++
 rtl/spi_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_bus_arbiter_if.sv
// Byte-stream request/response and SPI pin bundle for spi_bus_arbiter.
// master: the arbiter side; slave: requesters plus the external SPI device.
interface spi_bus_arbiter_if;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic [1:0]  grant;
    logic        busy;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;

    modport master (
        input  req_valid, req_data, req_last, spi_miso,
        output req_ready, rsp_valid, rsp_data, grant, busy,
               spi_sclk, spi_cs_n, spi_mosi
    );

    modport slave (
        output req_valid, req_data, req_last, spi_miso,
        input  req_ready, rsp_valid, rsp_data, grant, busy,
               spi_sclk, spi_cs_n, spi_mosi
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Two-requester round-robin arbiter in front of one SPI mode-0 master port.
// Define SPI_BUS_ARBITER_LOOPBACK_EN to receive from spi_mosi instead of spi_miso.
module spi_bus_arbiter #(
    parameter int CLK_DIV = 2,
    parameter int CS_IDLE = 2
) (
    input  logic              clk,
    input  logic              rst,
    spi_bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, HOLD} state_t;

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] HOLD_LAST = 8'(CS_IDLE - 1);

    state_t      state, state_next;
    logic        owner, rr_ptr, pick;
    logic        grant_now, accept, half_end, shift_done, hold_done, rx_bit;
    logic [7:0]  div_cnt, hold_cnt, tx_sr, rx_sr, rsp_data_q;
    logic [3:0]  half_cnt;
    logic        last_q;
    logic [1:0]  grant_q, rsp_valid_q, req_ready_c;
    logic        busy_q, sclk_q, cs_n_q, mosi_q;

`ifdef SPI_BUS_ARBITER_LOOPBACK_EN
    assign rx_bit = mosi_q;
`else
    assign rx_bit = bus.spi_miso;
`endif

    // NOTE: every variable gets a default at the top of always_comb so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_next  = state;
        pick        = rr_ptr;
        req_ready_c = 2'b00;
        if (bus.req_valid == 2'b01)
            pick = 1'b0;
        else if (bus.req_valid == 2'b10)
            pick = 1'b1;
        grant_now  = (state == IDLE) && (|bus.req_valid);
        accept     = (state == LOAD) && bus.req_valid[owner];
        half_end   = (div_cnt == DIV_LAST);
        shift_done = (state == SHIFT) && half_end && (half_cnt == 4'd15);
        hold_done  = (state == HOLD) && (hold_cnt == HOLD_LAST);
        if (state == LOAD)
            req_ready_c[owner] = bus.req_valid[owner];

        case (state)
            IDLE:    if (grant_now)  state_next = LOAD;
            LOAD:    if (accept)     state_next = SHIFT;
            SHIFT:   if (shift_done) state_next = last_q ? HOLD : LOAD;
            HOLD:    if (hold_done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // The pointer only flips on contention, so a lone requester never steals the other's turn.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner   <= 1'b0;
            rr_ptr  <= 1'b0;
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
        end else if (grant_now) begin
            owner   <= pick;
            grant_q <= pick ? 2'b10 : 2'b01;
            busy_q  <= 1'b1;
            if (&bus.req_valid)
                rr_ptr <= ~pick;
        end else if (hold_done) begin
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
        end
    end

    // half_cnt walks 16 half-bits: even = sclk low phase, odd = sclk high phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= 8'd0;
            half_cnt    <= 4'd0;
            hold_cnt    <= 8'd0;
            tx_sr       <= 8'd0;
            rx_sr       <= 8'd0;
            last_q      <= 1'b0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= 8'd0;
        end else begin
            rsp_valid_q <= 2'b00;
            case (state)
                LOAD: begin
                    if (accept) begin
                        tx_sr    <= owner ? bus.req_data[15:8] : bus.req_data[7:0];
                        mosi_q   <= owner ? bus.req_data[15] : bus.req_data[7];
                        last_q   <= bus.req_last[owner];
                        cs_n_q   <= 1'b0;
                        sclk_q   <= 1'b0;
                        div_cnt  <= 8'd0;
                        half_cnt <= 4'd0;
                    end
                end
                SHIFT: begin
                    if (half_end) begin
                        div_cnt  <= 8'd0;
                        half_cnt <= half_cnt + 4'd1;
                        if (!half_cnt[0]) begin
                            sclk_q <= 1'b1;
                            rx_sr  <= {rx_sr[6:0], rx_bit};
                        end else begin
                            sclk_q <= 1'b0;
                            if (half_cnt == 4'd15) begin
                                rsp_valid_q <= owner ? 2'b10 : 2'b01;
                                rsp_data_q  <= rx_sr;
                                cs_n_q      <= last_q;
                                mosi_q      <= 1'b0;
                                hold_cnt    <= 8'd0;
                            end else begin
                                tx_sr  <= {tx_sr[6:0], 1'b0};
                                mosi_q <= tx_sr[6];
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                HOLD:    hold_cnt <= hold_cnt + 8'd1;
                default: ;
            endcase
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;
    assign bus.spi_sclk  = sclk_q;
    assign bus.spi_cs_n  = cs_n_q;
    assign bus.spi_mosi  = mosi_q;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: a byte-returning SPI slave model, an
// expected-response queue drained by a monitor, and inline pin-timing checks.
module tb_spi_bus_arbiter;
    localparam int CLK_DIV = 2;
    localparam int CS_IDLE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    spi_bus_arbiter_if bus ();

    spi_bus_arbiter #(.CLK_DIV(CLK_DIV), .CS_IDLE(CS_IDLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [1:0] who;
        logic [7:0] data;
    } rsp_t;

    rsp_t       exp_q[$];
    logic [7:0] slave_q[$];

    // Mode-0 slave: presents bit 7 once selected, advances on every sclk fall.
    logic [7:0] slave_cur = 8'd0;
    int         bit_idx   = 0;
    logic       loaded    = 1'b0;
    logic       sclk_prev = 1'b0;
    logic       tie_miso0 = 1'b0;

    always @(negedge clk) begin
        if (bus.spi_cs_n !== 1'b0) begin
            bit_idx = 0;
            loaded  = 1'b0;
        end else begin
            if (sclk_prev && !bus.spi_sclk) begin
                bit_idx++;
                if (bit_idx == 8) begin
                    bit_idx = 0;
                    loaded  = 1'b0;
                end
            end
            if (!loaded && slave_q.size() > 0) begin
                slave_cur = slave_q.pop_front();
                loaded    = 1'b1;
            end
        end
        sclk_prev    = bus.spi_sclk;
        bus.spi_miso = (loaded && !tie_miso0) ? slave_cur[7 - bit_idx] : 1'b0;
    end

    always @(negedge clk) begin
        rsp_t e;
        if (bus.rsp_valid !== 2'b00) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", {22'd0, bus.rsp_valid, bus.rsp_data}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_owner", bus.rsp_valid, e.who);
                check("rsp_data", bus.rsp_data, e.data);
            end
        end
    end

    task automatic drive(input int r, input logic [7:0] d, input logic last);
        bus.req_valid[r] = 1'b1;
        bus.req_last[r]  = last;
        if (r == 0)
            bus.req_data[7:0] = d;
        else
            bus.req_data[15:8] = d;
    endtask

    // Called at a falling edge; returns at the falling edge of the response
    // cycle, or after the CS idle window when last is set.
    task automatic send_byte(input int r, input logic [7:0] d, input logic last, input logic [7:0] ret);
        int         t;
        int         k;
        int         b;
        bit         ok;
        logic [1:0] oh;
        rsp_t       e;
        oh = (r == 0) ? 2'b01 : 2'b10;
        slave_q.push_back(ret);
        e.who = oh;
`ifdef SPI_BUS_ARBITER_LOOPBACK_EN
        e.data = d;
`else
        e.data = ret;
`endif
        exp_q.push_back(e);
        drive(r, d, last);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (bus.req_ready[r] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept_timeout", {31'd0, ok}, 32'd1);
        if (!ok) begin
            bus.req_valid[r] = 1'b0;
            return;
        end
        t = cyc;
        @(posedge clk);
        #1;
        bus.req_valid[r] = 1'b0;
        for (int c = t + 1; c <= t + 16 * CLK_DIV + 1; c++) begin
            @(negedge clk);
            k = c - t;
            if (k == 1) begin
                check("cs_n_low_at_t1", bus.spi_cs_n, 1'b0);
                check("mosi_bit7_at_t1", bus.spi_mosi, d[7]);
                check("sclk_low_at_t1", bus.spi_sclk, 1'b0);
            end
            if (k >= 1 + CLK_DIV && k <= 16 * CLK_DIV && ((k - 1 - CLK_DIV) % (2 * CLK_DIV)) == 0) begin
                b = (k - 1 - CLK_DIV) / (2 * CLK_DIV);
                check("sclk_rise", bus.spi_sclk, 1'b1);
                check("mosi_at_rise", bus.spi_mosi, d[7 - b]);
            end
            if (k == 16 * CLK_DIV) begin
                check("cs_n_low_end", bus.spi_cs_n, 1'b0);
                check("no_rsp_early", bus.rsp_valid, 2'b00);
            end
            if (k == 16 * CLK_DIV + 1) begin
                check("rsp_pulse", bus.rsp_valid, oh);
                check("sclk_low_after", bus.spi_sclk, 1'b0);
                check("cs_n_after_byte", bus.spi_cs_n, last);
                check("grant_held", bus.grant, oh);
            end
        end
        if (last) begin
            for (int h = 2; h <= CS_IDLE; h++) begin
                @(negedge clk);
                check("hold_cs_n_high", bus.spi_cs_n, 1'b1);
                check("hold_busy", bus.busy, 1'b1);
            end
            @(negedge clk);
            check("grant_cleared", bus.grant, 2'b00);
            check("busy_cleared", bus.busy, 1'b0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 2'b00;
        bus.req_data  = 16'd0;
        bus.req_last  = 2'b00;
        repeat (3) @(negedge clk);

        check("rst_cs_n", bus.spi_cs_n, 1'b1);
        check("rst_sclk", bus.spi_sclk, 1'b0);
        check("rst_mosi", bus.spi_mosi, 1'b0);
        check("rst_req_ready", bus.req_ready, 2'b00);
        check("rst_rsp_valid", bus.rsp_valid, 2'b00);
        check("rst_rsp_data", bus.rsp_data, 8'h00);
        check("rst_grant", bus.grant, 2'b00);
        check("rst_busy", bus.busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Single-byte packet from requester 0.
        drive(0, 8'hA5, 1'b1);
        @(negedge clk);
        check("t1_grant", bus.grant, 2'b01);
        check("t1_busy", bus.busy, 1'b1);
        check("t1_ready", bus.req_ready, 2'b01);
        check("t1_cs_n_before_accept", bus.spi_cs_n, 1'b1);
        send_byte(0, 8'hA5, 1'b1, 8'h3C);

        // Three-byte packet from requester 1; requester 0 waits its turn.
        @(negedge clk);
        send_byte(1, 8'h01, 1'b0, 8'h81);
        drive(0, 8'h99, 1'b1);
        #1;
        check("t3_nonowner_ready", bus.req_ready, 2'b00);
        check("t3_grant_kept", bus.grant, 2'b10);
        send_byte(1, 8'h02, 1'b0, 8'h42);
        send_byte(1, 8'h03, 1'b1, 8'h24);
        @(negedge clk);
        check("t3_req0_granted", bus.grant, 2'b01);
        check("t3_req0_ready", bus.req_ready, 2'b01);
        send_byte(0, 8'h99, 1'b1, 8'h66);

        // Owner stalls between bytes.
        @(negedge clk);
        send_byte(0, 8'h12, 1'b0, 8'h5A);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("gap_cs_n", bus.spi_cs_n, 1'b0);
            check("gap_sclk", bus.spi_sclk, 1'b0);
            check("gap_grant", bus.grant, 2'b01);
        end
        send_byte(0, 8'h34, 1'b1, 8'hA7);

        // Reset in the middle of shifting 0x55.
        @(negedge clk);
        drive(0, 8'h55, 1'b1);
        for (int i = 0; i < 50; i++) begin
            #1;
            if (bus.req_ready[0] === 1'b1) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        repeat (3 * CLK_DIV) @(negedge clk);
        check("mid_shift_cs_n", bus.spi_cs_n, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_cs_n", bus.spi_cs_n, 1'b1);
        check("rst_mid_sclk", bus.spi_sclk, 1'b0);
        check("rst_mid_mosi", bus.spi_mosi, 1'b0);
        check("rst_mid_grant", bus.grant, 2'b00);
        check("rst_mid_busy", bus.busy, 1'b0);
        check("rst_mid_rsp", bus.rsp_valid, 2'b00);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("rst_mid_idle_grant", bus.grant, 2'b00);

        // Contention: pointer starts at requester 0 and flips on each tie.
        drive(0, 8'hF0, 1'b1);
        drive(1, 8'h0F, 1'b1);
        @(negedge clk);
        check("rr1_grant_req0", bus.grant, 2'b01);
        check("rr1_ready", bus.req_ready, 2'b01);
        send_byte(0, 8'hF0, 1'b1, 8'h11);
        @(negedge clk);
        check("rr1_then_req1", bus.grant, 2'b10);
        send_byte(1, 8'h0F, 1'b1, 8'h22);
        drive(0, 8'hC0, 1'b1);
        drive(1, 8'h0C, 1'b1);
        @(negedge clk);
        check("rr2_grant_req1", bus.grant, 2'b10);
        send_byte(1, 8'h0C, 1'b1, 8'h33);
        @(negedge clk);
        check("rr2_then_req0", bus.grant, 2'b01);
        send_byte(0, 8'hC0, 1'b1, 8'h44);

`ifdef SPI_BUS_ARBITER_LOOPBACK_EN
        tie_miso0 = 1'b1;
        @(negedge clk);
        send_byte(0, 8'hC3, 1'b1, 8'h00);
        tie_miso0 = 1'b0;
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
